col_packer: RTL and testbench

- Upstream feeder for the four-slot column register bank.
- Accepts a narrow word stream through a valid/ready handshake and packs words into one col_addr_width-bit column vector.
- Presents each completed vector with a one-cycle slot code (1..4), so the downstream bank latches columns 1, 2, 3, 4 in order.
- One start pulse loads one group of four columns.

---
 rtl/col_packer.sv | 121 ++++++++++++
 tb/tb_col_packer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/col_packer.sv
// Packs a narrow valid/ready word stream into wide column vectors and issues
// them to a four-slot column bank as slot codes 1..4, one group per start pulse.
module col_packer #(
    parameter int col_addr_width = 2560,
    parameter int word_width     = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [word_width-1:0]     in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [col_addr_width-1:0] col_addr_out,
    output logic [2:0]                control,
    output logic                      busy,
    output logic                      group_done
);
    localparam int WORDS = col_addr_width / word_width;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [CNT_W-1:0]          word_cnt_r;
    logic [2:0]                slot_r;
    logic [col_addr_width-1:0] pack_r;
    logic [col_addr_width-1:0] merged_s;
    logic                      hs_s;
    logic                      last_s;

    // Handshake decode and merge of the incoming word into the packing register
    always_comb begin
        in_ready = (state_r == PACK);
        hs_s     = in_valid && (state_r == PACK);
        last_s   = hs_s && (word_cnt_r == LAST_CNT);
        merged_s = pack_r;
        merged_s[word_cnt_r*word_width +: word_width] = in_data;
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = PACK;
                else       state_s = IDLE;
            end
            PACK: begin
                if (last_s) state_s = ISSUE;
                else        state_s = PACK;
            end
            ISSUE: begin
                if (slot_r == 3'd4) state_s = IDLE;
                else                state_s = PACK;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Packing datapath, slot tracking and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            pack_r       <= '0;
            word_cnt_r   <= '0;
            slot_r       <= 3'd1;
            col_addr_out <= '0;
            control      <= 3'd0;
            busy         <= 1'b0;
            group_done   <= 1'b0;
        end else begin
            control    <= 3'd0;
            group_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        word_cnt_r <= '0;
                        slot_r     <= 3'd1;
                        busy       <= 1'b1;
                    end
                end
                PACK: begin
                    if (last_s) begin
                        // Completed column goes out with its slot code; packer restarts empty
                        col_addr_out <= merged_s;
                        control      <= slot_r;
                        word_cnt_r   <= '0;
                        pack_r       <= '0;
                    end else if (hs_s) begin
                        pack_r     <= merged_s;
                        word_cnt_r <= word_cnt_r + CNT_W'(1);
                    end
                end
                ISSUE: begin
                    if (slot_r == 3'd4) begin
                        slot_r     <= 3'd1;
                        busy       <= 1'b0;
                        group_done <= 1'b1;
                    end else begin
                        slot_r <= slot_r + 3'd1;
                    end
                end
                default: begin
                    word_cnt_r <= '0;
                    slot_r     <= 3'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_col_packer.sv
// Self-checking bench for col_packer: directed steps feed words, a scoreboard
// queue holds expected columns/slots that a negedge monitor pops on each control pulse.
module tb_col_packer;
    localparam int CW    = 2560;
    localparam int WW    = 32;
    localparam int WORDS = CW / WW;
    localparam int GUARD = 3000;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [WW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] col_addr_out;
    logic [2:0]    control;
    logic          busy;
    logic          group_done;

    col_packer #(.col_addr_width(CW), .word_width(WW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .col_addr_out(col_addr_out), .control(control),
        .busy(busy), .group_done(group_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]    slot;
        logic [CW-1:0] col;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e_cur;
    int            pulse_cyc[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    bit            mon_en   = 1'b0;
    bit            prev4    = 1'b0;
    logic [CW-1:0] col_model;
    int            widx;
    logic [2:0]    slot_model;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic col_check(input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        int bad;
        bad = -1;
        for (int k = 0; k < WORDS; k++)
            if (bad < 0 && obs[k*WW +: WW] !== expv[k*WW +: WW]) bad = k;
        if (bad < 0) bad = 0;
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL column_data word %0d observed=%0h expected=%0h",
                   bad, obs[bad*WW +: WW], expv[bad*WW +: WW]);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_col"},        64'(col_addr_out === '0), 64'd1);
        check({tag, "_control"},    64'(control),    64'd0);
        check({tag, "_in_ready"},   64'(in_ready),   64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_group_done"}, 64'(group_done), 64'd0);
    endtask

    task automatic model_reset();
        col_model  = '0;
        widx       = 0;
        slot_model = 3'd1;
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
    endtask

    // Drives n words (base+i) with optional 1,0,0,1 valid pattern; start pulsed when sent==start_at.
    task automatic feed(input int n, input int base, input bit bp, input int start_at);
        int sent;
        int ph;
        int guard;
        sent  = 0;
        ph    = 0;
        guard = 0;
        while (sent < n && guard < GUARD) begin
            @(negedge clock);
            guard++;
            in_valid = bp ? ((ph % 4) == 0 || (ph % 4) == 3) : 1'b1;
            ph++;
            in_data = WW'(base + sent);
            start   = (sent == start_at);
            if (in_valid && in_ready) begin
                col_model[widx*WW +: WW] = in_data;
                widx++;
                sent++;
                if (widx == WORDS) begin
                    exp_q.push_back('{slot_model, col_model});
                    slot_model = (slot_model == 3'd4) ? 3'd1 : slot_model + 3'd1;
                    widx       = 0;
                    col_model  = '0;
                end
            end
        end
        check("feed_in_time", 64'(guard < GUARD), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Monitor: scoreboard pop on every control pulse, group_done follows slot 4
    always @(negedge clock) begin
        cyc++;
        if (mon_en) begin
            check("group_done_after_slot4", 64'(group_done), 64'(prev4));
            if (group_done) check("busy_falls_with_done", 64'(busy), 64'd0);
            prev4 = (control == 3'd4);
            if (control !== 3'd0) begin
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 64'(control), 64'd0);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("control_slot", 64'(control), 64'(e_cur.slot));
                    col_check(col_addr_out, e_cur.col);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();

        // 1. reset held 3 cycles with random start/in_valid
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_zero("reset_hold");
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
        end
        @(negedge clock);
        check_zero("reset_last");
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check_zero("after_reset");
        mon_en = 1'b1;

        // 2. single group, continuous valid, data = word index
        pulse_cyc.delete();
        do_start();
        feed(4 * WORDS, 0, 1'b0, -1);
        @(negedge clock);
        @(negedge clock);
        check("t2_pulses", 64'(pulse_cyc.size()), 64'd4);
        if (pulse_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                check("t2_spacing", 64'(pulse_cyc[i] - pulse_cyc[i-1]), 64'(WORDS + 1));
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t2_busy_idle", 64'(busy), 64'd0);
        check("t2_ready_idle", 64'(in_ready), 64'd0);

        // 3. backpressure pattern 1,0,0,1
        pulse_cyc.delete();
        do_start();
        feed(4 * WORDS, 10000, 1'b1, -1);
        @(negedge clock);
        @(negedge clock);
        check("t3_pulses", 64'(pulse_cyc.size()), 64'd4);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t3_busy_idle", 64'(busy), 64'd0);

        // 4. start pulsed mid-PACK of slot 2 is ignored
        pulse_cyc.delete();
        do_start();
        feed(4 * WORDS, 20000, 1'b0, WORDS + 20);
        for (int i = 0; i < 6; i++) @(negedge clock);
        check("t4_pulses", 64'(pulse_cyc.size()), 64'd4);
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t4_busy_idle", 64'(busy), 64'd0);
        check("t4_ready_idle", 64'(in_ready), 64'd0);

        // 5. reset after 40 words of slot 3, then a fresh group
        pulse_cyc.delete();
        do_start();
        feed(2 * WORDS + 40, 30000, 1'b0, -1);
        check("t5_in_pack", 64'(in_ready), 64'd1);
        check("t5_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_zero("t5_after_reset");
        check("t5_pulses_before", 64'(pulse_cyc.size()), 64'd2);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        model_reset();
        pulse_cyc.delete();
        do_start();
        feed(4 * WORDS, 40000, 1'b0, -1);
        @(negedge clock);
        @(negedge clock);
        check("t5_pulses_after", 64'(pulse_cyc.size()), 64'd4);
        check("t5_queue_empty2", 64'(exp_q.size()), 64'd0);

        // 6. back-to-back groups, start in the group_done cycle
        pulse_cyc.delete();
        do_start();
        feed(4 * WORDS, 50000, 1'b0, -1);
        @(negedge clock);
        check("t6_done_cycle", 64'(group_done), 64'd1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("t6_no_bubble_ready", 64'(in_ready), 64'd1);
        check("t6_busy_again", 64'(busy), 64'd1);
        feed(4 * WORDS, 60000, 1'b0, -1);
        @(negedge clock);
        @(negedge clock);
        check("t6_pulses", 64'(pulse_cyc.size()), 64'd8);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t6_busy_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
